ex_stage: RTL and testbench

- Execute stage of the 5-stage pipeline; the consumer of the ex_* fields that the ID/EX pipeline register presents.
- Computes logic, shift and arithmetic results, and passes the link address for jump/branch-and-link.
- Runs a 32-iteration sequential divider that writes HI/LO.
- While the divider runs, raises a stall request to pipeline control, which holds stall[2] and keeps the ID/EX outputs stable.

---
 rtl/ex_stage.sv | 246 ++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline. Single-cycle logic/shift/arith/link
//   results are combinational from the ex_* inputs (zero added latency); DIV/DIVU run a
//   32-iteration restoring divider writing HI/LO.
// Backpressure: stallreq_o holds the pipeline while a divide is in progress; the
//   ID/EX register keeps ex_* stable until the END cycle.
//
// Ports:
//   clk, reset_n           clock and asynchronous active-low reset
//   ex_alusel, ex_aluop    operation class and operation within class
//   ex_reg1_data/reg2_data operands (reg1[4:0] is the shift amount, reg2 is shifted)
//   ex_we, ex_waddr        GPR write enable / destination from ID
//   ex_link_address        return address for jump/branch-and-link
//   ex_is_in_delayslot     delay-slot flag, forwarded as is_in_delayslot_o
//   wb_wdata/wb_we/wb_waddr GPR write to EX/MEM
//   hi_o, lo_o, whilo_o    HI/LO result and write strobe (divider END cycle only)
//   stallreq_o             stall request to pipeline control
//
// Optional feature macro: EX_OVERFLOW_EN -- signed overflow on ADD/SUB suppresses wb_we.

module ex_stage #(
  parameter int DIV_CYCLES = 32  // only 32 is supported
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  ex_alusel,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_reg1_data,
  input  logic [31:0] ex_reg2_data,
  input  logic        ex_we,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_link_address,
  input  logic        ex_is_in_delayslot,
  output logic [31:0] wb_wdata,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq_o,
  output logic        is_in_delayslot_o
);

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_DIV   = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;
  localparam logic [2:0] SEL_JB    = 3'b110;

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h20;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUB  = 8'h22;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [4:0] LAST_ITER = 5'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DBZ  = 2'd1,
    S_ON   = 2'd2,
    S_END  = 2'd3
  } div_state_t;

  div_state_t  state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] pr;        // partial remainder (upper) / dividend-then-quotient (lower)
  logic [31:0] dvs;       // divisor magnitude
  logic        neg_quo;
  logic        neg_rem;
  logic [31:0] quo;
  logic [31:0] rem;

  logic        div_op;
  logic        div_signed;
  logic        r1_neg;
  logic        r2_neg;
  logic [31:0] r1_mag;
  logic [31:0] r2_mag;
  logic [63:0] rem_sh;
  logic [32:0] trial;
  logic [63:0] pr_nxt;

  logic [31:0] sum;
  logic [31:0] diff;
  logic        slt;
  logic        sltu;
  logic        ovf;
  logic [31:0] alu_res;

  assign div_op     = (ex_alusel == SEL_DIV) && (ex_aluop == OP_DIV || ex_aluop == OP_DIVU);
  assign div_signed = (ex_aluop == OP_DIV);
  assign r1_neg     = div_signed & ex_reg1_data[31];
  assign r2_neg     = div_signed & ex_reg2_data[31];
  assign r1_mag     = r1_neg ? (~ex_reg1_data + 32'd1) : ex_reg1_data;
  assign r2_mag     = r2_neg ? (~ex_reg2_data + 32'd1) : ex_reg2_data;

  // One restoring step: shift left, try subtracting the divisor from the upper half;
  // on success keep the difference and shift a 1 into the quotient.
  assign rem_sh = {pr[62:0], 1'b0};
  assign trial  = {1'b0, rem_sh[63:32]} - {1'b0, dvs};
  assign pr_nxt = trial[32] ? rem_sh : {trial[31:0], rem_sh[31:1], 1'b1};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (div_op) state_nxt = (ex_reg2_data == 32'd0) ? S_DBZ : S_ON;
      S_DBZ:   state_nxt = S_END;
      S_ON:    if (cnt == LAST_ITER) state_nxt = S_END;
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Divider datapath; operands and signs are captured at start so mid-divide input
  // changes cannot corrupt the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      pr      <= '0;
      dvs     <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      quo     <= '0;
      rem     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (div_op && ex_reg2_data != 32'd0) begin
            pr      <= {32'd0, r1_mag};
            dvs     <= r2_mag;
            neg_quo <= r1_neg ^ r2_neg;
            neg_rem <= r1_neg;
            cnt     <= '0;
          end
        end
        S_DBZ: begin
          quo <= '0;
          rem <= '0;
        end
        S_ON: begin
          pr  <= pr_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == LAST_ITER) begin
            quo <= neg_quo ? (~pr_nxt[31:0] + 32'd1) : pr_nxt[31:0];
            rem <= neg_rem ? (~pr_nxt[63:32] + 32'd1) : pr_nxt[63:32];
          end
        end
        default: ;
      endcase
    end
  end

  // Single-cycle ALU
  assign sum  = ex_reg1_data + ex_reg2_data;
  assign diff = ex_reg1_data - ex_reg2_data;
  assign slt  = $signed(ex_reg1_data) < $signed(ex_reg2_data);
  assign sltu = ex_reg1_data < ex_reg2_data;

`ifdef EX_OVERFLOW_EN
  // Overflow when the result sign differs from operand 1 under same-sign add or
  // different-sign subtract.
  assign ovf = (ex_alusel == SEL_ARITH) &&
               (((ex_aluop == OP_ADD) && (ex_reg1_data[31] == ex_reg2_data[31]) &&
                 (sum[31] != ex_reg1_data[31])) ||
                ((ex_aluop == OP_SUB) && (ex_reg1_data[31] != ex_reg2_data[31]) &&
                 (diff[31] != ex_reg1_data[31])));
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    case (ex_alusel)
      SEL_LOGIC: begin
        case (ex_aluop)
          OP_AND:  alu_res = ex_reg1_data & ex_reg2_data;
          OP_OR:   alu_res = ex_reg1_data | ex_reg2_data;
          OP_XOR:  alu_res = ex_reg1_data ^ ex_reg2_data;
          OP_NOR:  alu_res = ~(ex_reg1_data | ex_reg2_data);
          default: alu_res = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (ex_aluop)
          OP_SLL:  alu_res = ex_reg2_data << ex_reg1_data[4:0];
          OP_SRL:  alu_res = ex_reg2_data >> ex_reg1_data[4:0];
          OP_SRA:  alu_res = $unsigned($signed(ex_reg2_data) >>> ex_reg1_data[4:0]);
          default: alu_res = '0;
        endcase
      end
      SEL_ARITH: begin
        case (ex_aluop)
          OP_ADD, OP_ADDU: alu_res = sum;
          OP_SUB, OP_SUBU: alu_res = diff;
          OP_SLT:          alu_res = {31'd0, slt};
          OP_SLTU:         alu_res = {31'd0, sltu};
          default:         alu_res = '0;
        endcase
      end
      SEL_JB:  alu_res = ex_link_address;
      default: alu_res = '0;
    endcase
  end

  // Output stage; every output is held at zero while reset is asserted.
  always_comb begin
    wb_wdata          = '0;
    wb_we             = 1'b0;
    wb_waddr          = '0;
    hi_o              = '0;
    lo_o              = '0;
    whilo_o           = 1'b0;
    stallreq_o        = 1'b0;
    is_in_delayslot_o = 1'b0;
    if (reset_n) begin
      wb_wdata          = alu_res;
      wb_we             = ex_we & ~div_op & ~ovf;
      wb_waddr          = ex_waddr;
      is_in_delayslot_o = ex_is_in_delayslot;
      stallreq_o        = div_op && (state != S_END);
      if (state == S_END) begin
        whilo_o = 1'b1;
        lo_o    = quo;
        hi_o    = rem;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage. Stimulus pushes expected results into
// queues; a monitor on the falling edge pops and compares whenever a vector is
// presented (sequence strobe) or the DUT raises whilo_o.

module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  ex_alusel;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_reg1_data;
  logic [31:0] ex_reg2_data;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_link_address;
  logic        ex_is_in_delayslot;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;
  logic        stallreq_o;
  logic        is_in_delayslot_o;

  ex_stage dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .ex_alusel         (ex_alusel),
    .ex_aluop          (ex_aluop),
    .ex_reg1_data      (ex_reg1_data),
    .ex_reg2_data      (ex_reg2_data),
    .ex_we             (ex_we),
    .ex_waddr          (ex_waddr),
    .ex_link_address   (ex_link_address),
    .ex_is_in_delayslot(ex_is_in_delayslot),
    .wb_wdata          (wb_wdata),
    .wb_we             (wb_we),
    .wb_waddr          (wb_waddr),
    .hi_o              (hi_o),
    .lo_o              (lo_o),
    .whilo_o           (whilo_o),
    .stallreq_o        (stallreq_o),
    .is_in_delayslot_o (is_in_delayslot_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wdata;
    logic        we;
    logic [4:0]  waddr;
    logic        dslot;
  } wb_exp_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          stall;
  } div_exp_t;

  wb_exp_t  wq[$];
  div_exp_t dq[$];
  int       n_vec = 0;
  int       n_err = 0;
  int       seq   = 0;

`ifdef EX_OVERFLOW_EN
  localparam logic OVF_WE = 1'b0;
`else
  localparam logic OVF_WE = 1'b1;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: falling-edge sampling, decoupled from stimulus.
  initial begin : monitor
    int seen = 0;
    int run  = 0;
    wb_exp_t  we_r;
    div_exp_t de;
    forever begin
      @(negedge clk);
      if (seq != seen) begin
        seen = seq;
        if (wq.size() == 0) begin
          chk("wb_queue_underflow", 32'd1, 32'd0);
        end else begin
          we_r = wq.pop_front();
          chk("wb_wdata", wb_wdata, we_r.wdata);
          chk("wb_we", {31'd0, wb_we}, {31'd0, we_r.we});
          chk("wb_waddr", {27'd0, wb_waddr}, {27'd0, we_r.waddr});
          chk("is_in_delayslot_o", {31'd0, is_in_delayslot_o}, {31'd0, we_r.dslot});
          chk("stall_on_vector", {31'd0, stallreq_o}, 32'd0);
          chk("whilo_on_vector", {31'd0, whilo_o}, 32'd0);
        end
      end
      if (whilo_o) begin
        if (dq.size() == 0) begin
          chk("unexpected_whilo", 32'd1, 32'd0);
        end else begin
          de = dq.pop_front();
          chk("lo_o", lo_o, de.lo);
          chk("hi_o", hi_o, de.hi);
          chk("stall_cycles", 32'(run), 32'(de.stall));
          chk("wb_we_on_div", {31'd0, wb_we}, 32'd0);
        end
        run = 0;
      end else if (stallreq_o) begin
        run++;
      end else begin
        run = 0;
      end
    end
  end

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] r1,
                       input logic [31:0] r2, input logic we, input logic [4:0] wa,
                       input logic [31:0] link, input logic ds);
    ex_alusel          = sel;
    ex_aluop           = op;
    ex_reg1_data       = r1;
    ex_reg2_data       = r2;
    ex_we              = we;
    ex_waddr           = wa;
    ex_link_address    = link;
    ex_is_in_delayslot = ds;
  endtask

  task automatic apply(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wa, input logic [31:0] link,
                       input logic ds, input logic [31:0] exp_d, input logic exp_we);
    @(posedge clk); #1;
    drive(sel, op, r1, r2, 1'b1, wa, link, ds);
    wq.push_back('{wdata: exp_d, we: exp_we, waddr: wa, dslot: ds});
    seq++;
  endtask

  task automatic nop();
    @(posedge clk); #1;
    drive(3'b000, 8'h00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  // Issue a divide and hold it until the DUT drops stallreq_o (END cycle).
  task automatic run_div(input logic [7:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int exp_st);
    bit done = 0;
    @(posedge clk); #1;
    drive(3'b011, op, r1, r2, 1'b1, 5'd9, 32'd0, 1'b0);
    dq.push_back('{lo: exp_lo, hi: exp_hi, stall: exp_st});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stallreq_o) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("div_timeout", 32'd1, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset with live inputs: every output must read zero.
    reset_n = 1'b0;
    drive(3'b001, 8'h24, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 5'd5, 32'h0, 1'b1);
    @(posedge clk); #1;
    wq.push_back('{wdata: 32'd0, we: 1'b0, waddr: 5'd0, dslot: 1'b0});
    seq++;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Logic
    apply(3'b001, 8'h24, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd5, 32'h0, 1'b0, 32'h00F0_1234, 1'b1);
    apply(3'b001, 8'h25, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd6, 32'h0, 1'b0, 32'hFFF0_FFFF, 1'b1);
    apply(3'b001, 8'h26, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd6, 32'h0, 1'b0, 32'hFF00_EDCB, 1'b1);
    apply(3'b001, 8'h27, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd6, 32'h0, 1'b0, 32'h000F_0000, 1'b1);
    apply(3'b001, 8'h55, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd6, 32'h0, 1'b0, 32'h0, 1'b1);
    // Shift
    apply(3'b010, 8'h03, 32'd4, 32'h8000_0010, 5'd7, 32'h0, 1'b0, 32'hF800_0001, 1'b1);
    apply(3'b010, 8'h02, 32'd4, 32'h8000_0010, 5'd7, 32'h0, 1'b0, 32'h0800_0001, 1'b1);
    apply(3'b010, 8'h7C, 32'd4, 32'h8000_0010, 5'd7, 32'h0, 1'b0, 32'h0000_0100, 1'b1);
    // Arithmetic
    apply(3'b100, 8'h20, 32'h7FFF_FFFF, 32'd1, 5'd8, 32'h0, 1'b0, 32'h8000_0000, OVF_WE);
    apply(3'b100, 8'h22, 32'h8000_0000, 32'd1, 5'd8, 32'h0, 1'b0, 32'h7FFF_FFFF, OVF_WE);
    apply(3'b100, 8'h20, 32'd5, 32'd7, 5'd8, 32'h0, 1'b0, 32'd12, 1'b1);
    apply(3'b100, 8'h21, 32'h7FFF_FFFF, 32'd1, 5'd8, 32'h0, 1'b0, 32'h8000_0000, 1'b1);
    apply(3'b100, 8'h23, 32'd5, 32'd7, 5'd8, 32'h0, 1'b0, 32'hFFFF_FFFE, 1'b1);
    apply(3'b100, 8'h2A, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'h0, 1'b0, 32'd1, 1'b1);
    apply(3'b100, 8'h2B, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'h0, 1'b0, 32'd0, 1'b1);
    // Jump/branch link and NOP
    apply(3'b110, 8'h00, 32'h1, 32'h2, 5'd31, 32'h0000_0108, 1'b1, 32'h0000_0108, 1'b1);
    apply(3'b000, 8'h00, 32'h1234, 32'h5678, 5'd3, 32'h0000_0108, 1'b0, 32'h0, 1'b1);

    // Signed divide then unsigned divide back-to-back
    run_div(8'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div(8'h1B, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    nop();
    // Divide by zero
    run_div(8'h1A, 32'd5, 32'd0, 32'd0, 32'd0, 2);
    nop();

    // Reset in the middle of a divide: aborts with no HI/LO write.
    @(posedge clk); #1;
    drive(3'b011, 8'h1A, 32'd1000, 32'd3, 1'b1, 5'd9, 32'h0, 1'b1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    wq.push_back('{wdata: 32'd0, we: 1'b0, waddr: 5'd0, dslot: 1'b0});
    seq++;
    nop();
    @(posedge clk); #1;
    reset_n = 1'b1;
    apply(3'b000, 8'h00, 32'h0, 32'h0, 5'd2, 32'h0, 1'b0, 32'h0, 1'b1);
    // FSM must be back in IDLE: fresh divides behave normally.
    run_div(8'h1A, 32'd9, 32'd0, 32'd0, 32'd0, 2);
    run_div(8'h1B, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 33);
    nop();

    repeat (3) @(posedge clk);
    chk("wb_queue_drained", 32'(wq.size()), 32'd0);
    chk("div_queue_drained", 32'(dq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
